// File: rtl/rst_sequencer.sv
// Staged reset sequencer: synchronizes an external reset request, holds every
// domain in reset for HOLD_CYCLES clean cycles, then releases rst_n_out[0..N-1]
// one at a time, STAGE_GAP cycles apart.
// Optional software reset handshake (sw_rst_req / sw_rst_ack) is compiled in
// only when RST_SEQ_SW_REQ_EN is defined.
module rst_sequencer #(
  parameter int unsigned NUM_DOM     = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ext_rst_in,
`ifdef RST_SEQ_SW_REQ_EN
  input  logic               sw_rst_req,
`endif
  output logic [NUM_DOM-1:0] rst_n_out,
  output logic               rst_done
`ifdef RST_SEQ_SW_REQ_EN
  ,
  output logic               sw_rst_ack
`endif
);

  localparam int unsigned CntMax = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast  = CntW'(STAGE_GAP - 1);

  typedef enum logic [1:0] {StAssert, StHold, StRelease, StRun} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ext_sync;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_DOM-1:0]     rst_n_q, rst_n_d;
  logic [NUM_DOM-1:0]     rst_n_next;
  logic                   done_q, done_d;
  logic                   ext_restart;
  logic                   sw_restart;
  logic                   enter_run;

  // Two-or-more flop synchronizer for the asynchronous external request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ext_rst_in};
    end
  end

  assign ext_sync = sync_q[SYNC_STAGES-1];

  // Next released-bit pattern: one more low-order bit set
  assign rst_n_next = (rst_n_q << 1) | NUM_DOM'(1);

  // The ASSERT state always advances, so an external request only restarts from later states
  assign ext_restart = ext_sync && (state_q != StAssert);

`ifdef RST_SEQ_SW_REQ_EN
  logic sw_flag_q, sw_flag_d;
  logic ack_q, ack_d;

  assign sw_restart = sw_rst_req && (state_q == StRun) && !ext_sync;
`else
  assign sw_restart = 1'b0;
`endif

  // Sequencer state, shared hold/gap counter and release pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  // Next-state: hold counting, staged release, and restart override
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_n_d   = rst_n_q;
    done_d    = done_q;
    enter_run = 1'b0;
    case (state_q)
      StAssert: begin
        state_d = StHold;
        cnt_d   = '0;
        rst_n_d = '0;
        done_d  = 1'b0;
      end
      StHold, StRelease: begin
        if (cnt_q == ((state_q == StHold) ? HoldLast : GapLast)) begin
          cnt_d   = '0;
          rst_n_d = rst_n_next;
          if (&rst_n_next) begin
            state_d   = StRun;
            done_d    = 1'b1;
            enter_run = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        rst_n_d = '1;
      end
      default: begin
        state_d = StAssert;
      end
    endcase
    if (ext_restart || sw_restart) begin
      state_d   = StAssert;
      cnt_d     = '0;
      rst_n_d   = '0;
      done_d    = 1'b0;
      enter_run = 1'b0;
    end
  end

`ifdef RST_SEQ_SW_REQ_EN
  // Software-sequence flag and completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_flag_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      sw_flag_q <= sw_flag_d;
      ack_q     <= ack_d;
    end
  end

  // External restart cancels a pending software sequence; ack fires on re-entering RUN
  always_comb begin
    sw_flag_d = sw_flag_q;
    ack_d     = 1'b0;
    if (ext_restart) begin
      sw_flag_d = 1'b0;
    end else if (sw_restart) begin
      sw_flag_d = 1'b1;
    end else if (enter_run && sw_flag_q) begin
      sw_flag_d = 1'b0;
      ack_d     = 1'b1;
    end
  end

  assign sw_rst_ack = ack_q;
`endif

  assign rst_n_out = rst_n_q;
  assign rst_done  = done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: directed scenarios plus a random stretch, every cycle
// checked against a timing model that derives outputs from the edge count since
// the latest restart. Build with RST_SEQ_SW_REQ_EN to cover the software handshake.
module tb_rst_sequencer;

  localparam int N    = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int SYNC = 2;
  localparam int RUN_EL = 1 + HOLD + (N - 1) * GAP;

  logic         clk;
  logic         reset;
  logic         ext_rst_in;
  logic         sw_rst_req;
  logic [N-1:0] rst_n_out;
  logic         rst_done;
`ifdef RST_SEQ_SW_REQ_EN
  logic         sw_rst_ack;
`endif

  rst_sequencer #(
    .NUM_DOM    (N),
    .HOLD_CYCLES(HOLD),
    .STAGE_GAP  (GAP),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ext_rst_in(ext_rst_in),
`ifdef RST_SEQ_SW_REQ_EN
    .sw_rst_req(sw_rst_req),
    .sw_rst_ack(sw_rst_ack),
`endif
    .rst_n_out (rst_n_out),
    .rst_done  (rst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: t = edges since reset release, r = edge of latest restart (0 = reset release)
  int t;
  int r;
  bit flag;
  bit exp_ack;
  bit ext_at[0:4095];

  task automatic check_reset_state();
    checks++;
    assert (rst_n_out === '0) else begin
      failures++;
      $error("FAIL reset_rst_n got=%b exp=%b", rst_n_out, {N{1'b0}});
    end
    checks++;
    assert (rst_done === 1'b0) else begin
      failures++;
      $error("FAIL reset_done got=%b exp=0", rst_done);
    end
`ifdef RST_SEQ_SW_REQ_EN
    checks++;
    assert (sw_rst_ack === 1'b0) else begin
      failures++;
      $error("FAIL reset_ack got=%b exp=0", sw_rst_ack);
    end
`endif
  endtask

  task automatic do_reset();
    ext_rst_in = 1'b0;
    sw_rst_req = 1'b0;
    reset      = 1'b1;
    #1;
    check_reset_state();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    t     = 0;
    r     = 0;
    flag  = 1'b0;
  endtask

  // Drive one cycle of inputs, advance an edge, update the model, check outputs
  task automatic cycle(input bit e, input bit s);
    bit           es;
    bit           s_eff;
    bit           in_run_prev;
    int           el;
    logic [N-1:0] exp_n;
    ext_rst_in = e;
    sw_rst_req = s;
    @(posedge clk);
    t++;
    ext_at[t] = e;
`ifdef RST_SEQ_SW_REQ_EN
    s_eff = s;
`else
    s_eff = 1'b0;
`endif
    es          = (t > SYNC) ? ext_at[t-SYNC] : 1'b0;
    in_run_prev = ((t - 1 - r) >= RUN_EL);
    exp_ack     = 1'b0;
    if (es && (t != r + 1)) begin
      r    = t;
      flag = 1'b0;
    end else if (s_eff && in_run_prev) begin
      r    = t;
      flag = 1'b1;
    end
    el = t - r;
    for (int i = 0; i < N; i++) exp_n[i] = (el >= 1 + HOLD + i * GAP);
    if (flag && (el == RUN_EL)) begin
      exp_ack = 1'b1;
      flag    = 1'b0;
    end
    #1;
    checks++;
    assert (rst_n_out === exp_n) else begin
      failures++;
      $error("FAIL rst_n_out edge=%0d got=%b exp=%b", t, rst_n_out, exp_n);
    end
    checks++;
    assert (rst_done === (el >= RUN_EL)) else begin
      failures++;
      $error("FAIL rst_done edge=%0d got=%b exp=%b", t, rst_done, (el >= RUN_EL));
    end
`ifdef RST_SEQ_SW_REQ_EN
    checks++;
    assert (sw_rst_ack === exp_ack) else begin
      failures++;
      $error("FAIL sw_rst_ack edge=%0d got=%b exp=%b", t, sw_rst_ack, exp_ack);
    end
`endif
  endtask

  initial begin
    reset      = 1'b1;
    ext_rst_in = 1'b0;
    sw_rst_req = 1'b0;
    #3;
    do_reset();

    // Clean power-up release, then an external request while in RUN
    repeat (32) cycle(1'b0, 1'b0);
    repeat (17) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0);

    // Software request in RUN; ignored request during RELEASE; sw + ext together
    cycle(1'b0, 1'b1);
    repeat (35) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (35) cycle(1'b0, 1'b0);

    // External pulse during HOLD restarts the clean-cycle count
    do_reset();
    repeat (9) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    repeat (40) cycle(1'b0, 1'b0);

    // Random external and software requests
    for (int k = 0; k < 400; k++) begin
      cycle(($urandom_range(0, 99) < 3), ($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges 23 and 24 aborts the release at once
    do_reset();
    repeat (23) cycle(1'b0, 1'b0);
    #2;
    do_reset();
    repeat (35) cycle(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
